theta_delta_extractor: RTL and testbench

Inverse of the angle accumulator: converts a stream of absolute, normalized angle samples (microradians, range [0, 2π·10^6)) into signed per-sample increments `delta_theta` along the shortest arc. It sits between an absolute-heading source (compass or encoder front end) and consumers that expect incremental rotation. It performs wrap-around unwrapping, so a crossing of 0/2π yields a small signed step rather than a ±2π jump. Input and output use valid/ready handshakes.

---
 rtl/theta_delta_extractor.sv | 132 +++++++++++++
 tb/tb_theta_delta_extractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/theta_delta_extractor.sv
`default_nettype none
// ============================================================================
// Module      : theta_delta_extractor
// Description : Converts absolute wrapped angle samples into signed
//               shortest-arc increments with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module theta_delta_extractor #(
    parameter int unsigned W            = 64,
    parameter longint      TWO_PI_MICRO = 6283185,
    parameter longint      PI_MICRO     = 3141592
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                limpa,
    input  logic                amostra,
    input  logic signed [W-1:0] theta_in,
    output logic                pronto,
    output logic signed [W-1:0] delta_theta,
    output logic                delta_valido,
    input  logic                delta_aceito,
    output logic                erro
);

    localparam logic signed [W-1:0] c_two_pi  = W'(TWO_PI_MICRO);
    localparam logic signed [W-1:0] c_pi      = W'(PI_MICRO);
    localparam logic signed [W-1:0] c_neg_pi  = -W'(PI_MICRO);

    typedef enum logic [1:0] {
        SEM_REF   = 2'd0,
        ESPERA    = 2'd1,
        NORMALIZA = 2'd2,
        ENTREGA   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic signed [W-1:0] r_theta_ant;
    logic signed [W-1:0] r_diff;
    logic signed [W-1:0] r_delta;
    logic                r_delta_valido;
    logic                r_erro;

    logic                w_accept;
    logic                w_in_range;
    logic                w_good;
    logic                w_bad;
    logic signed [W-1:0] w_corrected;

    assign pronto       = (r_state == SEM_REF) || (r_state == ESPERA);
    assign delta_theta  = r_delta;
    assign delta_valido = r_delta_valido;
    assign erro         = r_erro;

    // limpa wins over any sample presented in the same cycle
    assign w_accept   = amostra && pronto && !limpa;
    assign w_in_range = !theta_in[W-1] && (theta_in < c_two_pi);
    assign w_good     = w_accept && w_in_range;
    assign w_bad      = w_accept && !w_in_range;

    // |diff| < 2*pi, so a single correction lands inside [-pi, pi]
    always_comb begin
        w_corrected = r_diff;
        if (r_diff > c_pi) begin
            w_corrected = r_diff - c_two_pi;
        end else if (r_diff < c_neg_pi) begin
            w_corrected = r_diff + c_two_pi;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (limpa) begin
            w_state_next = SEM_REF;
        end else begin
            case (r_state)
                SEM_REF:   if (w_good) w_state_next = ESPERA;
                ESPERA:    if (w_good) w_state_next = NORMALIZA;
                NORMALIZA: w_state_next = ENTREGA;
                ENTREGA:   if (delta_aceito) w_state_next = ESPERA;
                default:   w_state_next = SEM_REF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEM_REF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_theta_ant    <= '0;
            r_diff         <= '0;
            r_delta        <= '0;
            r_delta_valido <= 1'b0;
            r_erro         <= 1'b0;
        end else if (limpa) begin
            r_theta_ant    <= '0;
            r_diff         <= '0;
            r_delta        <= '0;
            r_delta_valido <= 1'b0;
            r_erro         <= 1'b0;
        end else begin
            r_erro <= w_bad;
            case (r_state)
                SEM_REF: begin
                    if (w_good) r_theta_ant <= theta_in;
                end
                ESPERA: begin
                    if (w_good) begin
                        r_diff      <= theta_in - r_theta_ant;
                        r_theta_ant <= theta_in;
                    end
                end
                NORMALIZA: begin
                    r_delta        <= w_corrected;
                    r_delta_valido <= 1'b1;
                end
                ENTREGA: begin
                    if (delta_aceito) r_delta_valido <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_theta_delta_extractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_theta_delta_extractor
// Description : Directed self-checking bench for theta_delta_extractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_theta_delta_extractor;

    logic               clk = 1'b0;
    logic               reset;
    logic               limpa;
    logic               amostra;
    logic signed [63:0] theta_in;
    logic               pronto;
    logic signed [63:0] delta_theta;
    logic               delta_valido;
    logic               delta_aceito;
    logic               erro;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    theta_delta_extractor dut (
        .clk          (clk),
        .reset        (reset),
        .limpa        (limpa),
        .amostra      (amostra),
        .theta_in     (theta_in),
        .pronto       (pronto),
        .delta_theta  (delta_theta),
        .delta_valido (delta_valido),
        .delta_aceito (delta_aceito),
        .erro         (erro)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint t);
        amostra  = 1'b1;
        theta_in = t;
        step();
        amostra  = 1'b0;
        theta_in = '0;
    endtask

    // Waits (bounded) for the delta, checks it, then accepts it.
    task automatic expect_delta(input string tag, input longint exp);
        int n;
        n = 0;
        while (!delta_valido && n < 6) begin
            step();
            n++;
        end
        check_value({tag, "_valid"}, {63'd0, delta_valido}, 64'd1);
        check_value({tag, "_delta"}, delta_theta, exp);
        delta_aceito = 1'b1;
        step();
        delta_aceito = 1'b0;
        check_value({tag, "_cleared"}, {63'd0, delta_valido}, 64'd0);
    endtask

    task automatic expect_none(input string tag);
        step();
        step();
        check_value({tag, "_novalid"}, {63'd0, delta_valido}, 64'd0);
        check_value({tag, "_pronto"}, {63'd0, pronto}, 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        limpa        = 1'b0;
        amostra      = 1'b0;
        theta_in     = '0;
        delta_aceito = 1'b0;
        #2;
        check_value("rst_pronto", {63'd0, pronto}, 64'd1);
        check_value("rst_valid", {63'd0, delta_valido}, 64'd0);
        check_value("rst_erro", {63'd0, erro}, 64'd0);
        check_value("rst_delta", delta_theta, 64'd0);
        step();
        reset = 1'b1;

        // Basic difference, latency and hold
        send(1000000);
        check_value("ref_only", {63'd0, delta_valido}, 64'd0);
        send(1500000);
        check_value("norm_pronto", {63'd0, pronto}, 64'd0);
        check_value("norm_valid", {63'd0, delta_valido}, 64'd0);
        step();
        check_value("lat_valid", {63'd0, delta_valido}, 64'd1);
        check_value("lat_delta", delta_theta, 64'sd500000);
        step();
        step();
        check_value("hold_valid", {63'd0, delta_valido}, 64'd1);
        check_value("hold_delta", delta_theta, 64'sd500000);
        check_value("hold_pronto", {63'd0, pronto}, 64'd0);
        // Sample alongside acceptance is ignored; acceptance honoured
        amostra      = 1'b1;
        theta_in     = 64'sd4000000;
        delta_aceito = 1'b1;
        step();
        amostra      = 1'b0;
        delta_aceito = 1'b0;
        check_value("acc_valid", {63'd0, delta_valido}, 64'd0);
        check_value("acc_pronto", {63'd0, pronto}, 64'd1);

        // Reference still 1500000
        send(6200000);
        expect_delta("big_neg", -64'sd1583185);
        send(100000);
        expect_delta("wrap_fwd", 64'sd183185);
        send(6200000);
        expect_delta("wrap_bwd", -64'sd183185);

        // Boundaries
        do_reset();
        send(0);
        send(3141592);
        expect_delta("plus_pi", 64'sd3141592);
        do_reset();
        send(0);
        send(3141593);
        expect_delta("pi_plus1", -64'sd3141592);
        send(0);
        expect_delta("minus_pi_m1", 64'sd3141592);

        // Out-of-range samples (reference 0)
        send(6283185);
        check_value("err_hi_pulse", {63'd0, erro}, 64'd1);
        check_value("err_hi_pronto", {63'd0, pronto}, 64'd1);
        step();
        check_value("err_hi_end", {63'd0, erro}, 64'd0);
        check_value("err_hi_novalid", {63'd0, delta_valido}, 64'd0);
        send(-1);
        check_value("err_neg_pulse", {63'd0, erro}, 64'd1);
        step();
        check_value("err_neg_end", {63'd0, erro}, 64'd0);
        send(500000);
        expect_delta("after_err", 64'sd500000);

        // limpa with amostra in ESPERA
        limpa    = 1'b1;
        amostra  = 1'b1;
        theta_in = 64'sd700000;
        step();
        limpa    = 1'b0;
        amostra  = 1'b0;
        check_value("limpa_erro", {63'd0, erro}, 64'd0);
        check_value("limpa_valid", {63'd0, delta_valido}, 64'd0);
        check_value("limpa_pronto", {63'd0, pronto}, 64'd1);
        send(900000);
        expect_none("limpa_next");
        send(1000000);
        expect_delta("limpa_after", 64'sd100000);

        // Asynchronous reset while ENTREGA holds a delta
        send(1200000);
        step();
        check_value("pre_rst_valid", {63'd0, delta_valido}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_value("async_valid", {63'd0, delta_valido}, 64'd0);
        check_value("async_pronto", {63'd0, pronto}, 64'd1);
        check_value("async_delta", delta_theta, 64'd0);
        step();
        reset = 1'b1;
        send(2000000);
        expect_none("rst_next");
        send(2100000);
        expect_delta("rst_after", 64'sd100000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
